datapath_arbiter: RTL and testbench

- Shares one register-file + ALU datapath (regfile, ALUsrc mux, ALU) between two independent requesters, e.g. the core control path and a debug/loader engine.
- Each requester issues one operation through a valid/ready handshake:
  - operands: rs1, rs2, rd, ALUsrc, ALUctrl, ImmOp, write-enable.
  - result (ALUout, EQ) is returned through a second valid/ready response handshake.
- Round-robin arbitration.
- At most one operation in flight.
- Sits between the requesters and the datapath and drives all of the datapath's control/address inputs.

---
 rtl/datapath_arbiter.sv | 127 ++++++++++++
 tb/tb_datapath_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter sharing one regfile+ALU datapath between two requesters.
// One operation in flight: accept in IDLE, hold the captured result in RESP until consumed.
module datapath_arbiter #(
    parameter int REGWIDTH  = 5,
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r0_valid,
    output logic                 r0_ready,
    input  logic [REGWIDTH-1:0]  r0_rs1,
    input  logic [REGWIDTH-1:0]  r0_rs2,
    input  logic [REGWIDTH-1:0]  r0_rd,
    input  logic                 r0_alusrc,
    input  logic [2:0]           r0_aluctrl,
    input  logic [DATAWIDTH-1:0] r0_imm,
    input  logic                 r0_wr,
    output logic                 r0_rsp_valid,
    input  logic                 r0_rsp_ready,
    input  logic                 r1_valid,
    output logic                 r1_ready,
    input  logic [REGWIDTH-1:0]  r1_rs1,
    input  logic [REGWIDTH-1:0]  r1_rs2,
    input  logic [REGWIDTH-1:0]  r1_rd,
    input  logic                 r1_alusrc,
    input  logic [2:0]           r1_aluctrl,
    input  logic [DATAWIDTH-1:0] r1_imm,
    input  logic                 r1_wr,
    output logic                 r1_rsp_valid,
    input  logic                 r1_rsp_ready,
    output logic [DATAWIDTH-1:0] rsp_data,
    output logic                 rsp_eq,
    output logic [REGWIDTH-1:0]  dp_rs1,
    output logic [REGWIDTH-1:0]  dp_rs2,
    output logic [REGWIDTH-1:0]  dp_rd,
    output logic                 dp_regwrite,
    output logic                 dp_alusrc,
    output logic [2:0]           dp_aluctrl,
    output logic [DATAWIDTH-1:0] dp_imm,
    output logic [DATAWIDTH-1:0] dp_writedata,
    input  logic [DATAWIDTH-1:0] dp_aluout,
    input  logic                 dp_eq
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state;
    logic                 last_grant;
    logic                 owner;
    logic [DATAWIDTH-1:0] rsp_data_q;
    logic                 rsp_eq_q;

    logic grant_vld;
    logic grant;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_vld = (state == IDLE) && (r0_valid || r1_valid);
        grant     = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
    end

    assign r0_ready = grant_vld && !grant;
    assign r1_ready = grant_vld && grant;

    always_comb begin
        dp_rs1      = '0;
        dp_rs2      = '0;
        dp_rd       = '0;
        dp_regwrite = 1'b0;
        dp_alusrc   = 1'b0;
        dp_aluctrl  = '0;
        dp_imm      = '0;
        if (grant_vld) begin
            if (grant) begin
                dp_rs1      = r1_rs1;
                dp_rs2      = r1_rs2;
                dp_rd       = r1_rd;
                dp_regwrite = r1_wr && (r1_rd != '0);
                dp_alusrc   = r1_alusrc;
                dp_aluctrl  = r1_aluctrl;
                dp_imm      = r1_imm;
            end else begin
                dp_rs1      = r0_rs1;
                dp_rs2      = r0_rs2;
                dp_rd       = r0_rd;
                dp_regwrite = r0_wr && (r0_rd != '0);
                dp_alusrc   = r0_alusrc;
                dp_aluctrl  = r0_aluctrl;
                dp_imm      = r0_imm;
            end
        end
    end

    assign dp_writedata = dp_aluout;

    assign r0_rsp_valid = (state == RESP) && !owner;
    assign r1_rsp_valid = (state == RESP) && owner;
    assign rsp_data     = rsp_data_q;
    assign rsp_eq       = rsp_eq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            rsp_data_q <= '0;
            rsp_eq_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        rsp_data_q <= dp_aluout;
                        rsp_eq_q   <= dp_eq;
                        owner      <= grant;
                        last_grant <= grant;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (owner ? r1_rsp_ready : r0_rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter with a behavioural regfile + ALU behind it.
module tb_datapath_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 0, r0_ready, r0_alusrc = 0, r0_wr = 0, r0_rsp_valid, r0_rsp_ready = 0;
    logic        r1_valid = 0, r1_ready, r1_alusrc = 0, r1_wr = 0, r1_rsp_valid, r1_rsp_ready = 0;
    logic [4:0]  r0_rs1 = 0, r0_rs2 = 0, r0_rd = 0, r1_rs1 = 0, r1_rs2 = 0, r1_rd = 0;
    logic [2:0]  r0_aluctrl = 0, r1_aluctrl = 0;
    logic [31:0] r0_imm = 0, r1_imm = 0;
    logic [31:0] rsp_data;
    logic        rsp_eq;
    logic [4:0]  dp_rs1, dp_rs2, dp_rd;
    logic        dp_regwrite, dp_alusrc;
    logic [2:0]  dp_aluctrl;
    logic [31:0] dp_imm, dp_writedata, dp_aluout;
    logic        dp_eq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_arbiter #(.REGWIDTH(5), .DATAWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_rs1(r0_rs1), .r0_rs2(r0_rs2), .r0_rd(r0_rd),
        .r0_alusrc(r0_alusrc), .r0_aluctrl(r0_aluctrl), .r0_imm(r0_imm), .r0_wr(r0_wr),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_rs1(r1_rs1), .r1_rs2(r1_rs2), .r1_rd(r1_rd),
        .r1_alusrc(r1_alusrc), .r1_aluctrl(r1_aluctrl), .r1_imm(r1_imm), .r1_wr(r1_wr),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data(rsp_data), .rsp_eq(rsp_eq),
        .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_rd(dp_rd), .dp_regwrite(dp_regwrite),
        .dp_alusrc(dp_alusrc), .dp_aluctrl(dp_aluctrl), .dp_imm(dp_imm),
        .dp_writedata(dp_writedata), .dp_aluout(dp_aluout), .dp_eq(dp_eq)
    );

    // Datapath model: plain storage (x0 not hardwired, so a leaked x0 write is visible).
    logic [31:0] regs [32] = '{default: 32'h0};
    logic [31:0] op1, op2;

    always @(posedge clk) if (dp_regwrite) regs[dp_rd] <= dp_writedata;

    always_comb begin
        op1 = regs[dp_rs1];
        op2 = dp_alusrc ? dp_imm : regs[dp_rs2];
        case (dp_aluctrl)
            3'b001:  dp_aluout = op1 - op2;
            3'b010:  dp_aluout = op1 & op2;
            3'b011:  dp_aluout = op1 | op2;
            3'b100:  dp_aluout = op1 ^ op2;
            default: dp_aluout = op1 + op2;
        endcase
        dp_eq = (dp_aluout == 32'h0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic src, input logic [2:0] ctrl, input logic [31:0] imm, input logic wr);
        r0_valid = v; r0_rs1 = rs1; r0_rs2 = rs2; r0_rd = rd;
        r0_alusrc = src; r0_aluctrl = ctrl; r0_imm = imm; r0_wr = wr;
    endtask

    task automatic set_r1(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic src, input logic [2:0] ctrl, input logic [31:0] imm, input logic wr);
        r1_valid = v; r1_rs1 = rs1; r1_rs2 = rs2; r1_rd = rd;
        r1_alusrc = src; r1_aluctrl = ctrl; r1_imm = imm; r1_wr = wr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        #1;
        checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", {r0_rsp_valid, r1_rsp_valid}); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (rsp_eq !== 1'b0) begin errors++; $display("FAIL reset_rsp_eq: got %b expected 0", rsp_eq); end
        checks++; if ({r0_ready, r1_ready, dp_regwrite} !== 3'b000) begin errors++; $display("FAIL reset_ready_we: got %b expected 000", {r0_ready, r1_ready, dp_regwrite}); end
        rst = 1'b0;
        step();
        #1;
        checks++; if ({dp_rs1, dp_rd, dp_imm} !== 42'h0) begin errors++; $display("FAIL idle_dp_zero: got %h expected 0", {dp_rs1, dp_rd, dp_imm}); end
    endtask

    task automatic test_basic_write();
        set_r0(1, 0, 0, 5, 1, 3'b000, 32'd7, 1);
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL basic_ready: got %b expected 10", {r0_ready, r1_ready}); end
        checks++; if (dp_regwrite !== 1'b1) begin errors++; $display("FAIL basic_regwrite: got %b expected 1", dp_regwrite); end
        checks++; if ({dp_rd, dp_imm, dp_alusrc} !== {5'd5, 32'd7, 1'b1}) begin errors++; $display("FAIL basic_dp_fields: got %h expected %h", {dp_rd, dp_imm, dp_alusrc}, {5'd5, 32'd7, 1'b1}); end
        step();
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b10) begin errors++; $display("FAIL basic_rsp_valid: got %b expected 10", {r0_rsp_valid, r1_rsp_valid}); end
        checks++; if (rsp_data !== 32'd7) begin errors++; $display("FAIL basic_rsp_data: got %0d expected 7", rsp_data); end
        r0_rsp_ready = 1;
        step();
        r0_rsp_ready = 0;
        #1;
        checks++; if (r0_rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_back_idle: got %b expected 0", r0_rsp_valid); end
    endtask

    task automatic test_dependent_ops();
        set_r1(1, 5, 0, 6, 1, 3'b000, 32'd3, 1);
        #1;
        checks++; if ({r0_ready, r1_ready} !== 2'b01) begin errors++; $display("FAIL dep_r1_ready: got %b expected 01", {r0_ready, r1_ready}); end
        step();
        set_r1(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r1_rsp_valid, rsp_data} !== {1'b1, 32'd10}) begin errors++; $display("FAIL dep_add_rsp: got %h expected %h", {r1_rsp_valid, rsp_data}, {1'b1, 32'd10}); end
        r1_rsp_ready = 1;
        step();
        r1_rsp_ready = 0;
        set_r0(1, 6, 6, 0, 0, 3'b001, 32'd0, 0);
        step();
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_rsp_valid, rsp_eq, rsp_data} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL dep_sub_eq: got %h expected %h", {r0_rsp_valid, rsp_eq, rsp_data}, {1'b1, 1'b1, 32'd0}); end
        r0_rsp_ready = 1;
        step();
        r0_rsp_ready = 0;
    endtask

    task automatic test_round_robin();
        logic e;
        rst = 1; step(); rst = 0;
        set_r0(1, 0, 0, 0, 1, 3'b000, 32'h11, 0);
        set_r1(1, 0, 0, 0, 1, 3'b000, 32'h22, 0);
        r0_rsp_ready = 1; r1_rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            e = i[0];
            #1;
            checks++; if ({r0_ready, r1_ready} !== {~e, e}) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, {r0_ready, r1_ready}, {~e, e}); end
            step();
            #1;
            checks++; if ({r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready} !== {~e, e, 2'b00}) begin errors++; $display("FAIL rr_resp_%0d: got %b expected %b", i, {r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready}, {~e, e, 2'b00}); end
            checks++; if (rsp_data !== (e ? 32'h22 : 32'h11)) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", i, rsp_data, (e ? 32'h22 : 32'h11)); end
            step();
        end
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0, 0, 0, 0);
        r0_rsp_ready = 0; r1_rsp_ready = 0;
    endtask

    task automatic test_backpressure();
        set_r0(1, 0, 0, 0, 1, 3'b000, 32'h55, 0);
        step();
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        set_r1(1, 0, 0, 7, 1, 3'b000, 32'h66, 1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({r0_rsp_valid, rsp_data, r1_ready, dp_regwrite} !== {1'b1, 32'h55, 2'b00}) begin errors++; $display("FAIL bp_hold_%0d: got %h expected %h", i, {r0_rsp_valid, rsp_data, r1_ready, dp_regwrite}, {1'b1, 32'h55, 2'b00}); end
            step();
        end
        set_r0(1, 0, 0, 0, 1, 3'b000, 32'h44, 0);
        r0_rsp_ready = 1;
        step();
        r0_rsp_ready = 0;
        #1;
        checks++; if ({r0_ready, r1_ready, dp_regwrite} !== 3'b011) begin errors++; $display("FAIL bp_waiter_wins: got %b expected 011", {r0_ready, r1_ready, dp_regwrite}); end
        step();
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r1_rsp_valid, rsp_data} !== {1'b1, 32'h66}) begin errors++; $display("FAIL bp_r1_rsp: got %h expected %h", {r1_rsp_valid, rsp_data}, {1'b1, 32'h66}); end
        r1_rsp_ready = 1;
        step();
        r1_rsp_ready = 0;
    endtask

    task automatic test_x0_write();
        set_r0(1, 0, 0, 0, 1, 3'b000, 32'd9, 1);
        #1;
        checks++; if ({r0_ready, dp_regwrite} !== 2'b10) begin errors++; $display("FAIL x0_regwrite: got %b expected 10", {r0_ready, dp_regwrite}); end
        step();
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_rsp_valid, rsp_data} !== {1'b1, 32'd9}) begin errors++; $display("FAIL x0_rsp: got %h expected %h", {r0_rsp_valid, rsp_data}, {1'b1, 32'd9}); end
        r0_rsp_ready = 1; step(); r0_rsp_ready = 0;
        set_r1(1, 0, 0, 0, 0, 3'b000, 32'd0, 0);
        step();
        set_r1(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r1_rsp_valid, rsp_eq, rsp_data} !== {2'b11, 32'd0}) begin errors++; $display("FAIL x0_read: got %h expected %h", {r1_rsp_valid, rsp_eq, rsp_data}, {2'b11, 32'd0}); end
        r1_rsp_ready = 1; step(); r1_rsp_ready = 0;
    endtask

    task automatic test_reset_in_grant();
        set_r1(1, 0, 0, 8, 1, 3'b000, 32'h99, 1);
        rst = 1;
        #1;
        checks++; if ({r1_ready, dp_regwrite} !== 2'b11) begin errors++; $display("FAIL rstgrant_ready_we: got %b expected 11", {r1_ready, dp_regwrite}); end
        step();
        rst = 0;
        set_r1(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rstgrant_no_resp: got %b expected 00", {r0_rsp_valid, r1_rsp_valid}); end
        set_r0(1, 8, 0, 0, 1, 3'b000, 32'd0, 0);
        step();
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_rsp_valid, rsp_data} !== {1'b1, 32'h99}) begin errors++; $display("FAIL rstgrant_write_kept: got %h expected %h", {r0_rsp_valid, rsp_data}, {1'b1, 32'h99}); end
        r0_rsp_ready = 1; step(); r0_rsp_ready = 0;
    endtask

    task automatic test_reset_in_resp();
        set_r1(1, 0, 0, 0, 1, 3'b000, 32'h77, 0);
        step();
        set_r1(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (r1_rsp_valid !== 1'b1) begin errors++; $display("FAIL rstresp_pending: got %b expected 1", r1_rsp_valid); end
        rst = 1;
        step();
        rst = 0;
        set_r0(1, 0, 0, 0, 1, 3'b000, 32'h12, 0);
        set_r1(1, 0, 0, 0, 1, 3'b000, 32'h34, 0);
        #1;
        checks++; if ({r0_rsp_valid, r1_rsp_valid, rsp_data} !== {2'b00, 32'h0}) begin errors++; $display("FAIL rstresp_cleared: got %h expected 0", {r0_rsp_valid, r1_rsp_valid, rsp_data}); end
        checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL rstresp_tie_r0: got %b expected 10", {r0_ready, r1_ready}); end
        step();
        set_r0(0, 0, 0, 0, 0, 0, 0, 0);
        set_r1(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_rsp_valid, rsp_data} !== {1'b1, 32'h12}) begin errors++; $display("FAIL rstresp_next_op: got %h expected %h", {r0_rsp_valid, rsp_data}, {1'b1, 32'h12}); end
        r0_rsp_ready = 1; step(); r0_rsp_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_write();
        test_dependent_ops();
        test_round_robin();
        test_backpressure();
        test_x0_write();
        test_reset_in_grant();
        test_reset_in_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
